// File: rtl/hs_fifo_level_if.sv
// rtl/hs_fifo_level_if.sv - valid/ready handshake bundle for hs_fifo_level
interface hs_fifo_level_if #(
  parameter int WIDTH = 1
);
  logic             valid_i;
  logic [WIDTH-1:0] in;
  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] out;
  logic             ready_i;

  // FIFO side: accepts upstream items, presents the head downstream
  modport slave (
    input  valid_i, in, ready_i,
    output ready_o, valid_o, out
  );

  // Environment side: produces upstream items, consumes the head
  modport master (
    output valid_i, in, ready_i,
    input  ready_o, valid_o, out
  );
endinterface

// File: rtl/hs_fifo_level.sv
// rtl/hs_fifo_level.sv - valid/ready FIFO with occupancy level, flags and high-watermark
module hs_fifo_level #(
  parameter  int WIDTH     = 1,
  parameter  int DEPTH     = 4,
  parameter  int AF_THRESH = 3,
  parameter  int AE_THRESH = 1,
  localparam int LW        = $clog2(DEPTH + 1)
) (
  input  logic           clk_core,
  input  logic           rst_core,
  input  logic           flush,
  hs_fifo_level_if.slave hs,
  output logic [LW-1:0]  level_o,
  output logic           almost_full_o,
  output logic           almost_empty_o,
  output logic [LW-1:0]  max_level_o
);

  localparam int PW = $clog2(DEPTH);

  if (DEPTH < 2) begin : g_chk_depth
    $error("hs_fifo_level: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_chk_af
    $error("hs_fifo_level: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_chk_ae
    $error("hs_fifo_level: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] rdata;     // unconditional registered read of mem[rd_ptr]
  logic             rvalid;    // rdata holds an item taken from mem last edge
  logic [WIDTH-1:0] skid;      // second output slot, filled while the head stalls
  logic             skid_v;
  logic [WIDTH-1:0] head;
  logic             head_v;

  logic             push;
  logic             pop;
  logic             issue;
  logic [1:0]       stage_cnt;
  logic [LW-1:0]    ram_cnt;
  logic [LW-1:0]    level_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign hs.ready_o = ~rst_core & (level_o != LW'(DEPTH));
  assign hs.valid_o = head_v;
  assign hs.out     = head;

  assign push = hs.ready_o & hs.valid_i;
  assign pop  = head_v & hs.ready_i;

  // Items already out of the array: head, skid and the read register in flight.
  assign stage_cnt = {1'b0, head_v} + {1'b0, skid_v} + {1'b0, rvalid};
  assign ram_cnt   = level_o - LW'(stage_cnt);

  // Take an item from the array only if the output stage is sure to have a
  // free slot for it on the next edge, whatever ready_i does then.
  assign issue = (ram_cnt != '0) && ((stage_cnt < 2'd2) || (pop && stage_cnt == 2'd2));

  assign almost_full_o  = (level_o >= LW'(AF_THRESH));
  assign almost_empty_o = (level_o <= LW'(AE_THRESH));

  // Next occupancy from this cycle's push/pop pair
  always_comb begin
    level_next = level_o;
    if (push && !pop) begin
      level_next = level_o + LW'(1);
    end else if (pop && !push) begin
      level_next = level_o - LW'(1);
    end
  end

  // Array write port; contents need no reset
  always_ff @(posedge clk_core) begin
    if (push && !flush) begin
      mem[wr_ptr] <= hs.in;
    end
  end

  // Array read port, read every cycle with no enable
  always_ff @(posedge clk_core) begin
    rdata <= mem[rd_ptr];
  end

  // Output stage payload: head refills from skid first, then from the read register
  always_ff @(posedge clk_core) begin
    if (pop || !head_v) begin
      head <= skid_v ? skid : rdata;
      skid <= rdata;
    end else if (rvalid) begin
      skid <= rdata;
    end
  end

  // Control state: pointers, occupancy, watermark and output-stage valids
  always_ff @(posedge clk_core) begin
    if (rst_core || flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_o     <= '0;
      max_level_o <= '0;
      rvalid      <= 1'b0;
      skid_v      <= 1'b0;
      head_v      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (issue) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      rvalid      <= issue;
      level_o     <= level_next;
      max_level_o <= (level_next > max_level_o) ? level_next : max_level_o;
      if (pop || !head_v) begin
        head_v <= skid_v | rvalid;
        skid_v <= skid_v & rvalid;
      end else if (rvalid) begin
        skid_v <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hs_fifo_level.sv
// tb/tb_hs_fifo_level.sv - self-checking bench for hs_fifo_level
module tb_hs_fifo_level;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush_a = 1'b0;
  logic flush_b = 1'b0;
  logic [2:0] level_a, max_a, level_b, max_b;
  logic af_a, ae_a, af_b, ae_b;

  int n_cmp = 0;
  int n_bad = 0;
  int lvl_a = 0, mx_a = 0, lvl_b = 0, mx_b = 0;
  int pops_b = 0;
  int pushed_b = 0;
  logic [7:0] sb_a[$];
  logic [7:0] sb_b[$];
  logic [7:0] held;

  always #5 clk = ~clk;

  hs_fifo_level_if #(.WIDTH(8)) ha ();
  hs_fifo_level_if #(.WIDTH(8)) hb ();

  hs_fifo_level #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1)) dut_a (
    .clk_core(clk), .rst_core(rst), .flush(flush_a), .hs(ha),
    .level_o(level_a), .almost_full_o(af_a), .almost_empty_o(ae_a), .max_level_o(max_a)
  );

  hs_fifo_level #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(2)) dut_b (
    .clk_core(clk), .rst_core(rst), .flush(flush_b), .hs(hb),
    .level_o(level_b), .almost_full_o(af_b), .almost_empty_o(ae_b), .max_level_o(max_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of DUT A: drive at negedge, score, then check state after the edge
  task automatic step_a(input logic v, input logic [7:0] d, input logic r, input logic fl);
    logic push, pop;
    ha.valid_i = v; ha.in = d; ha.ready_i = r; flush_a = fl;
    #1;
    check("a_ready", ha.ready_o, lvl_a != 4);
    push = v && (lvl_a != 4);
    pop  = ha.valid_o && r;
    if (fl) begin
      sb_a.delete(); lvl_a = 0; mx_a = 0;
    end else begin
      if (pop) begin
        check("a_pop_nonempty", sb_a.size() > 0, 1);
        if (sb_a.size() > 0) check("a_data", ha.out, sb_a.pop_front());
      end
      if (push) sb_a.push_back(d);
      lvl_a = lvl_a + int'(push) - int'(pop);
      if (lvl_a > mx_a) mx_a = lvl_a;
    end
    @(posedge clk);
    @(negedge clk);
    check("a_level", level_a, lvl_a);
    check("a_max", max_a, mx_a);
    check("a_af", af_a, lvl_a >= 3);
    check("a_ae", ae_a, lvl_a <= 1);
  endtask

  task automatic step_b(input logic v, input logic [7:0] d, input logic r);
    logic push, pop;
    hb.valid_i = v; hb.in = d; hb.ready_i = r;
    #1;
    check("b_ready", hb.ready_o, lvl_b != 5);
    push = v && (lvl_b != 5);
    pop  = hb.valid_o && r;
    if (pop) begin
      pops_b++;
      check("b_pop_nonempty", sb_b.size() > 0, 1);
      if (sb_b.size() > 0) check("b_data", hb.out, sb_b.pop_front());
    end
    if (push) sb_b.push_back(d);
    lvl_b = lvl_b + int'(push) - int'(pop);
    if (lvl_b > mx_b) mx_b = lvl_b;
    @(posedge clk);
    @(negedge clk);
    check("b_level", level_b, lvl_b);
    check("b_max", max_b, mx_b);
    check("b_af", af_b, lvl_b >= 4);
    check("b_ae", ae_b, lvl_b <= 2);
  endtask

  task automatic drain_a(input string tag);
    for (int k = 0; k < 40 && sb_a.size() > 0; k++) step_a(1'b0, 8'h00, 1'b1, 1'b0);
    check(tag, sb_a.size(), 0);
    check("a_empty_valid", ha.valid_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ha.valid_i = 1'b0; ha.in = '0; ha.ready_i = 1'b0;
    hb.valid_i = 1'b0; hb.in = '0; hb.ready_i = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready_a", ha.ready_o, 1'b0);
    check("rst_ready_b", hb.ready_o, 1'b0);
    check("rst_valid_a", ha.valid_o, 1'b0);
    check("rst_level_a", level_a, 0);
    check("rst_max_a", max_a, 0);
    check("rst_ae_a", ae_a, 1'b1);
    check("rst_af_a", af_a, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_ready_a", ha.ready_o, 1'b1);
    @(negedge clk);

    // Fill to full with the sink stalled, then drain in order
    for (int i = 0; i < 4; i++) step_a(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    check("t1_ready", ha.ready_o, 1'b0);
    check("t1_level", level_a, 4);
    check("t1_af", af_a, 1'b1);
    check("t1_max", max_a, 4);
    step_a(1'b0, 8'h00, 1'b0, 1'b0);
    step_a(1'b0, 8'h00, 1'b0, 1'b0);
    check("t1_head_valid", ha.valid_o, 1'b1);
    drain_a("t1_drain");

    // Two-cycle latency from push to valid head
    step_a(1'b1, 8'hA5, 1'b1, 1'b0);
    check("t2_valid_t", ha.valid_o, 1'b0);
    step_a(1'b0, 8'h00, 1'b1, 1'b0);
    check("t2_valid_t1", ha.valid_o, 1'b0);
    step_a(1'b0, 8'h00, 1'b1, 1'b0);
    check("t2_valid_t2", ha.valid_o, 1'b1);
    check("t2_out_t2", ha.out, 8'hA5);
    step_a(1'b0, 8'h00, 1'b1, 1'b0);
    check("t2_level_back", level_a, 0);

    // Full: offered item refused while a pop drains, then random traffic
    for (int i = 0; i < 4; i++) step_a(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    step_a(1'b0, 8'h00, 1'b0, 1'b0);
    step_a(1'b0, 8'h00, 1'b0, 1'b0);
    step_a(1'b1, 8'hEE, 1'b1, 1'b0);
    check("t3_level_after", level_a, 3);
    for (int i = 0; i < 100; i++)
      step_a(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    drain_a("t3_drain");

    // Non-power-of-two depth, random valid/ready, 20 items
    for (int k = 0; k < 300 && (pushed_b < 20 || sb_b.size() > 0); k++) begin
      logic v;
      v = (pushed_b < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (v && lvl_b != 5) pushed_b++;
      step_b(v, 8'h80 + 8'(pushed_b), 1'($urandom_range(0, 1)));
    end
    check("t4_sb_empty", sb_b.size(), 0);
    check("t4_pops", pops_b, 20);

    // Long stall holds the head, release continues without a gap
    for (int i = 0; i < 3; i++) step_a(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
    step_a(1'b0, 8'h00, 1'b0, 1'b0);
    step_a(1'b0, 8'h00, 1'b0, 1'b0);
    held = sb_a[0];
    for (int i = 0; i < 7; i++) begin
      step_a(1'b0, 8'h00, 1'b0, 1'b0);
      check("t5_hold_valid", ha.valid_o, 1'b1);
      check("t5_hold_out", ha.out, held);
    end
    step_a(1'b0, 8'h00, 1'b1, 1'b0);
    check("t5_next_valid", ha.valid_o, 1'b1);
    check("t5_next_out", ha.out, sb_a[0]);
    drain_a("t5_drain");

    // Flush at level 3 with a simultaneous push and pop
    for (int i = 0; i < 3; i++) step_a(1'b1, 8'h31 + 8'(i), 1'b0, 1'b0);
    step_a(1'b0, 8'h00, 1'b0, 1'b0);
    step_a(1'b0, 8'h00, 1'b0, 1'b0);
    check("t6_pre_level", level_a, 3);
    step_a(1'b1, 8'h77, 1'b1, 1'b1);
    check("t6_flush_level", level_a, 0);
    check("t6_flush_max", max_a, 0);
    check("t6_flush_valid", ha.valid_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step_a(1'b0, 8'h00, 1'b1, 1'b0);
      check("t6_no_ghost", ha.valid_o, 1'b0);
    end
    step_a(1'b1, 8'h41, 1'b1, 1'b0);
    step_a(1'b1, 8'h42, 1'b1, 1'b0);
    drain_a("t6_drain");

    // Reset mid-stream
    step_a(1'b1, 8'h61, 1'b0, 1'b0);
    step_a(1'b1, 8'h62, 1'b0, 1'b0);
    step_a(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_ready", ha.ready_o, 1'b0);
    check("t6_rst_valid", ha.valid_o, 1'b0);
    check("t6_rst_level", level_a, 0);
    check("t6_rst_max", max_a, 0);
    check("t6_rst_ae", ae_a, 1'b1);
    check("t6_rst_af", af_a, 1'b0);
    rst = 1'b0;
    sb_a.delete(); lvl_a = 0; mx_a = 0;
    sb_b.delete(); lvl_b = 0; mx_b = 0;
    for (int i = 0; i < 3; i++) begin
      step_a(1'b0, 8'h00, 1'b1, 1'b0);
      check("t6_post_rst_valid", ha.valid_o, 1'b0);
    end
    step_a(1'b1, 8'h99, 1'b1, 1'b0);
    drain_a("t6_post_rst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
